traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 SHALL have parameter TICK_ACTIVE, default 1'b1, giving the level of one_hz_enable that counts as a tick.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port one_hz_enable, input, 1, a one-cycle-wide pulse marking one second.
REQ-005 SHALL have port sensor, input, 1, side-street car present (level, sampled).
REQ-006 SHALL have port walk_request, input, 1, pedestrian button (level or pulse).
REQ-007 SHALL have port sync_reprogram, input, 1, already synchronised to clk; high when time parameters are being rewritten.
REQ-008 SHALL have port value_in, input, 4, the registered duration returned by the time-parameter store for the current interval.
REQ-009 SHALL have port interval, output, 2, duration select to the store: 00 base, 01 extended, 10 yellow; 11 never driven.
REQ-010 SHALL have port main_lights, output, 3, {red,yellow,green} for the main street.
REQ-011 SHALL have port side_lights, output, 3, {red,yellow,green} for the side street.
REQ-012 SHALL have port walk, output, 1, walk lamp.
REQ-013 SHALL have port time_left, output, 4, current countdown value.

Function
REQ-014 SHALL implement phases MG_BASE, MG_EXT, MY, SG_BASE, SG_EXT, SY, WALK, each with sub-steps FETCH0, FETCH1, RUN.
REQ-015 Each phase SHALL drive interval: MG_BASE/SG_BASE 00; MG_EXT/SG_EXT/WALK 01; MY/SY 10; interval SHALL be registered and stable from phase entry to phase exit.
REQ-016 The store's output lags interval by one registered cycle; the FSM SHALL spend exactly one cycle each in FETCH0 and FETCH1 and load the timer with value_in on the edge leaving FETCH1.
REQ-017 If value_in is 0 at load, the timer SHALL load 1.
REQ-018 In RUN, each tick SHALL decrement the timer; a tick in RUN with timer equal to 1 SHALL end the phase on that edge; ticks during FETCH0/FETCH1 SHALL be ignored.
REQ-019 Phase duration SHALL therefore be value_in ticks plus two clocks.
REQ-020 Transitions at expiry: MG_BASE goes to MG_EXT if sensor is 1 at expiry, otherwise to MY; MG_EXT goes to MY.
REQ-021 MY goes to SG_BASE. SG_BASE goes to SG_EXT if sensor is 1 at expiry, otherwise to SY. SG_EXT goes to SY.
REQ-022 SY goes to WALK if walk_pending, otherwise to MG_BASE. WALK goes to MG_BASE.
REQ-023 walk_pending SHALL set on any cycle with walk_request=1 and clear on the edge entering WALK; a request in the same cycle as WALK entry SHALL be dropped (already being served).
REQ-024 Lights SHALL be: MG_* 001/100; MY 010/100; SG_* 100/001; SY 100/010; WALK 100/100 with walk=1. walk SHALL be 0 in all other phases.
REQ-025 Lights SHALL change on the edge the phase is entered, including during FETCH0/FETCH1.
REQ-026 sync_reprogram=1 SHALL force MG_BASE/FETCH0 on the next edge, clear walk_pending and set the timer to 0; while held, the FSM SHALL remain in MG_BASE/FETCH0.
REQ-027 sync_reprogram SHALL take priority over tick and expiry.
REQ-028 time_left SHALL equal the timer register; it is 0 during FETCH0/FETCH1 of every phase.

Reset
REQ-029 On reset=1 at an edge: phase MG_BASE/FETCH0, interval=00, main_lights=001, side_lights=100, walk=0, time_left=0, walk_pending=0.
REQ-030 reset SHALL override sync_reprogram and all other inputs; reset mid-phase SHALL abandon the countdown immediately.

Verification
REQ-031 Store values base=6, ext=3, yel=2, tick every 10 clocks, sensor=0, no walk -> cycle MG 6 ticks, MY 2, SG 6, SY 2, back to MG; interval sequence 00,10,00,10.
REQ-032 sensor=1 at MG_BASE expiry -> MG_EXT with interval=01, 3 ticks green, then MY; sensor=0 at SG_BASE expiry -> SG_EXT skipped.
REQ-033 1-clock walk_request pulse during MG_BASE -> after SY: lights 100/100 and walk=1 for 3 ticks, then MG_BASE; no second WALK on the next cycle.
REQ-034 value_in=0 at load -> phase lasts 1 tick; tick during FETCH1 -> ignored, time_left still 0.
REQ-035 sync_reprogram pulsed mid-SG_BASE with walk pending -> next edge lights 001/100, interval=00, time_left=0, walk_pending=0.
REQ-036 reset asserted mid-SY while sync_reprogram=1 -> REQ-029 values on next edge; first load after release takes value_in on the 2nd edge.

Source files
------------

// File: rtl/traffic_light_fsm_if.sv
// ---------------------------------------------------------------------------
// traffic_light_fsm_if
//
// Connects the traffic-light controller to the time-parameter store.
// The controller selects which duration it needs and the store returns that
// duration from a register. The returned value therefore trails a change of
// interval by one clock.
//
// Signals
//   interval [1:0] : duration select, controller -> store
//                    00 base, 01 extended, 10 yellow (11 is never driven)
//   value_in [3:0] : registered duration, store -> controller
//
// Modports
//   master : the controller (drives interval, reads value_in)
//   slave  : the store      (reads interval, drives value_in)
// ---------------------------------------------------------------------------
interface traffic_light_fsm_if;
  logic [1:0] interval;
  logic [3:0] value_in;

  modport master (
    output interval,
    input  value_in
  );

  modport slave (
    input  interval,
    output value_in
  );
endinterface : traffic_light_fsm_if

// File: rtl/traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// traffic_light_fsm
//
// Controller for a main/side street crossing with a pedestrian walk phase.
// It cycles through seven phases:
//   MG_BASE -> (MG_EXT) -> MY -> SG_BASE -> (SG_EXT) -> SY -> (WALK) -> MG_BASE
// MG_EXT and SG_EXT are taken only when the side-street sensor is high as the
// base green expires. WALK is taken only when a walk request is pending.
//
// Each phase runs three sub-steps:
//   FETCH0 : interval has just changed, and the store is registering the value.
//   FETCH1 : value_in now holds the duration for this phase.
//   RUN    : the timer is loaded on the edge out of FETCH1. Each tick then
//            decrements it. A tick with the timer at 1 ends the phase.
// A phase therefore lasts value_in ticks plus two clocks. A duration of 0
// is treated as 1.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : synchronous, active-high; overrides every other input
//   one_hz_enable  : one-clock tick pulse, active level set by TICK_ACTIVE
//   sensor         : side-street car present (level)
//   walk_request   : pedestrian button (level or pulse)
//   sync_reprogram : store is being rewritten; holds MG_BASE/FETCH0
//   store_bus      : interval out / value_in in (time-parameter store)
//   main_lights    : {red,yellow,green}, main street
//   side_lights    : {red,yellow,green}, side street
//   walk           : walk lamp
//   time_left      : current countdown value (0 while fetching)
// ---------------------------------------------------------------------------
module traffic_light_fsm #(
  parameter logic TICK_ACTIVE = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       one_hz_enable,
  input  logic                       sensor,
  input  logic                       walk_request,
  input  logic                       sync_reprogram,
  traffic_light_fsm_if.master        store_bus,
  output logic [2:0]                 main_lights,
  output logic [2:0]                 side_lights,
  output logic                       walk,
  output logic [3:0]                 time_left
);

  // -------------------------------------------------------------------------
  // Types and encodings
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    MG_BASE,
    MG_EXT,
    MY,
    SG_BASE,
    SG_EXT,
    SY,
    WALK
  } phase_e;

  typedef enum logic [1:0] {
    FETCH0,
    FETCH1,
    RUN
  } step_e;

  // Everything a phase presents to the outside world. It is registered as
  // one unit so that all outputs change together on the phase-entry edge.
  typedef struct packed {
    logic [1:0] interval;
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk_l;
  } phase_out_t;

  localparam logic [1:0] INTERVAL_BASE = 2'b00;
  localparam logic [1:0] INTERVAL_EXT  = 2'b01;
  localparam logic [1:0] INTERVAL_YEL  = 2'b10;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // -------------------------------------------------------------------------
  // Phase tables
  // -------------------------------------------------------------------------
  // Output decode for each phase. The unreachable code falls back to the
  // MG_BASE outputs, so a corrupted state still shows a legal light pattern.
  function automatic phase_out_t phase_outputs(input phase_e p);
    phase_out_t o;
    o.interval = INTERVAL_BASE;
    o.main_l   = LAMP_GRN;
    o.side_l   = LAMP_RED;
    o.walk_l   = 1'b0;
    case (p)
      MG_BASE: begin
        o.interval = INTERVAL_BASE;
        o.main_l   = LAMP_GRN;
        o.side_l   = LAMP_RED;
      end
      MG_EXT: begin
        o.interval = INTERVAL_EXT;
        o.main_l   = LAMP_GRN;
        o.side_l   = LAMP_RED;
      end
      MY: begin
        o.interval = INTERVAL_YEL;
        o.main_l   = LAMP_YEL;
        o.side_l   = LAMP_RED;
      end
      SG_BASE: begin
        o.interval = INTERVAL_BASE;
        o.main_l   = LAMP_RED;
        o.side_l   = LAMP_GRN;
      end
      SG_EXT: begin
        o.interval = INTERVAL_EXT;
        o.main_l   = LAMP_RED;
        o.side_l   = LAMP_GRN;
      end
      SY: begin
        o.interval = INTERVAL_YEL;
        o.main_l   = LAMP_RED;
        o.side_l   = LAMP_YEL;
      end
      WALK: begin
        o.interval = INTERVAL_EXT;
        o.main_l   = LAMP_RED;
        o.side_l   = LAMP_RED;
        o.walk_l   = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Successor of a phase at expiry. The sensor is sampled on the expiry edge
  // itself. The walk decision uses the registered pending flag.
  function automatic phase_e phase_after(input phase_e p,
                                         input logic   sensor_now,
                                         input logic   walk_pending_now);
    phase_e nxt;
    nxt = MG_BASE;
    case (p)
      MG_BASE: nxt = sensor_now ? MG_EXT : MY;
      MG_EXT:  nxt = MY;
      MY:      nxt = SG_BASE;
      SG_BASE: nxt = sensor_now ? SG_EXT : SY;
      SG_EXT:  nxt = SY;
      SY:      nxt = walk_pending_now ? WALK : MG_BASE;
      WALK:    nxt = MG_BASE;
      default: nxt = MG_BASE;
    endcase
    return nxt;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  phase_e     phase_q,        phase_d;
  step_e      step_q,         step_d;
  logic [3:0] timer_q,        timer_d;
  logic       walk_pending_q, walk_pending_d;
  phase_out_t out_q,          out_d;

  logic       tick;

  assign tick = (one_hz_enable == TICK_ACTIVE);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal this block writes gets a default first. Otherwise a
    // path that skips an assignment would infer a latch.
    phase_d        = phase_q;
    step_d         = step_q;
    timer_d        = timer_q;
    walk_pending_d = walk_pending_q | walk_request;

    if (sync_reprogram) begin
      // The store contents are changing. Park at the start of the main green
      // and drop any walk request, which will be re-made if still wanted.
      phase_d        = MG_BASE;
      step_d         = FETCH0;
      timer_d        = 4'd0;
      walk_pending_d = 1'b0;
    end else begin
      case (step_q)
        FETCH0: step_d = FETCH1;

        FETCH1: begin
          // value_in is valid now: interval has been stable for one full
          // cycle, which covers the store's register stage.
          step_d  = RUN;
          timer_d = (store_bus.value_in == 4'd0) ? 4'd1 : store_bus.value_in;
        end

        RUN: begin
          if (tick) begin
            if (timer_q <= 4'd1) begin
              phase_d = phase_after(phase_q, sensor, walk_pending_q);
              step_d  = FETCH0;
              timer_d = 4'd0;
              // Entering WALK serves the request. A press on this same edge
              // is for the walk now starting, so it is not kept.
              if (phase_d == WALK) begin
                walk_pending_d = 1'b0;
              end
            end else begin
              timer_d = timer_q - 4'd1;
            end
          end
        end

        default: begin
          // Unused step code: restart the current phase's fetch.
          step_d  = FETCH0;
          timer_d = 4'd0;
        end
      endcase
    end

    out_d = phase_outputs(phase_d);
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments, so every register
  // here samples the values from before the edge, whatever the statement
  // order.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q        <= MG_BASE;
      step_q         <= FETCH0;
      timer_q        <= 4'd0;
      walk_pending_q <= 1'b0;
      out_q          <= phase_outputs(MG_BASE);
    end else begin
      phase_q        <= phase_d;
      step_q         <= step_d;
      timer_q        <= timer_d;
      walk_pending_q <= walk_pending_d;
      out_q          <= out_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign store_bus.interval = out_q.interval;
  assign main_lights        = out_q.main_l;
  assign side_lights        = out_q.side_l;
  assign walk               = out_q.walk_l;
  assign time_left          = timer_q;

endmodule : traffic_light_fsm

// File: tb/tb_traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_fsm
//
// Directed bench for traffic_light_fsm. A behavioural time-parameter store
// returns base/ext/yellow durations one register stage after interval
// changes. Inputs are driven and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_traffic_light_fsm;

  localparam logic TICK = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_hz_enable;
  logic       sensor;
  logic       walk_request;
  logic       sync_reprogram;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk;
  logic [3:0] time_left;

  logic [3:0] base_v;
  logic [3:0] ext_v;
  logic [3:0] yel_v;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_light_fsm_if store_bus ();

  traffic_light_fsm #(.TICK_ACTIVE(TICK)) dut (
    .clk            (clk),
    .reset          (reset),
    .one_hz_enable  (one_hz_enable),
    .sensor         (sensor),
    .walk_request   (walk_request),
    .sync_reprogram (sync_reprogram),
    .store_bus      (store_bus.master),
    .main_lights    (main_lights),
    .side_lights    (side_lights),
    .walk           (walk),
    .time_left      (time_left)
  );

  // Registered parameter store: value_in trails interval by one clock.
  always @(posedge clk) begin
    case (store_bus.interval)
      2'b00:   store_bus.value_in <= base_v;
      2'b01:   store_bus.value_in <= ext_v;
      2'b10:   store_bus.value_in <= yel_v;
      default: store_bus.value_in <= 4'd0;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_lamps(input string tag, input logic [2:0] m, input logic [2:0] s,
                             input logic w, input logic [1:0] iv);
    check({tag, " main"},     16'(main_lights),        16'(m));
    check({tag, " side"},     16'(side_lights),        16'(s));
    check({tag, " walk"},     16'(walk),               16'(w));
    check({tag, " interval"}, 16'(store_bus.interval), 16'(iv));
  endtask

  // Runs one whole phase. Entered at the falling edge just after the
  // phase-entry edge (FETCH0) and left at the falling edge just after the
  // expiry edge (FETCH0 of the next phase).
  task automatic run_phase(input string tag, input logic [2:0] m, input logic [2:0] s,
                           input logic w, input logic [1:0] iv, input int ticks,
                           input logic pulse_walk, input logic fetch_ticks);
    int n;
    bit done;
    check_lamps({tag, " f0"}, m, s, w, iv);
    check({tag, " f0 time_left"}, 16'(time_left), 16'd0);
    if (pulse_walk)  walk_request  = 1'b1;
    if (fetch_ticks) one_hz_enable = TICK;
    @(negedge clk);
    walk_request = 1'b0;
    check_lamps({tag, " f1"}, m, s, w, iv);
    check({tag, " f1 time_left"}, 16'(time_left), 16'd0);
    @(negedge clk);
    one_hz_enable = ~TICK;
    check_lamps({tag, " run"}, m, s, w, iv);
    check({tag, " load"}, 16'(time_left), 16'(ticks));
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      one_hz_enable = TICK;
      @(negedge clk);
      one_hz_enable = ~TICK;
      n++;
      if (time_left == 4'd0) begin
        done = 1'b1;
      end else begin
        check({tag, " count"}, 16'(time_left), 16'(ticks - n));
        repeat (9) @(negedge clk);
      end
    end
    check({tag, " ticks"}, 16'(n), 16'(ticks));
  endtask

  initial begin
    reset          = 1'b1;
    one_hz_enable  = ~TICK;
    sensor         = 1'b0;
    walk_request   = 1'b0;
    sync_reprogram = 1'b0;
    base_v         = 4'd6;
    ext_v          = 4'd3;
    yel_v          = 4'd2;

    // Reset state.
    repeat (2) @(negedge clk);
    check_lamps("reset", 3'b001, 3'b100, 1'b0, 2'b00);
    check("reset time_left", 16'(time_left), 16'd0);
    reset = 1'b0;

    // Basic cycle, no sensor, no walk.
    run_phase("r1 mg", 3'b001, 3'b100, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r1 my", 3'b010, 3'b100, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    run_phase("r1 sg", 3'b100, 3'b001, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r1 sy", 3'b100, 3'b010, 1'b0, 2'b10, 2, 1'b0, 1'b0);

    // Sensor high at main expiry -> extension; low at side expiry -> none.
    sensor = 1'b1;
    run_phase("r2 mg",    3'b001, 3'b100, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r2 mgext", 3'b001, 3'b100, 1'b0, 2'b01, 3, 1'b0, 1'b0);
    sensor = 1'b0;
    run_phase("r2 my",    3'b010, 3'b100, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    run_phase("r2 sg",    3'b100, 3'b001, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r2 sy",    3'b100, 3'b010, 1'b0, 2'b10, 2, 1'b0, 1'b0);

    // One-clock walk pulse during main green -> WALK after SY.
    run_phase("r3 mg",   3'b001, 3'b100, 1'b0, 2'b00, 6, 1'b1, 1'b0);
    run_phase("r3 my",   3'b010, 3'b100, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    run_phase("r3 sg",   3'b100, 3'b001, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r3 sy",   3'b100, 3'b010, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    base_v = 4'd0;
    run_phase("r3 walk", 3'b100, 3'b100, 1'b1, 2'b01, 3, 1'b0, 1'b0);

    // Zero duration loads 1; ticks during FETCH0/FETCH1 are ignored.
    // Ending back in MG_BASE also shows the walk request was consumed.
    run_phase("r4 mg", 3'b001, 3'b100, 1'b0, 2'b00, 1, 1'b0, 1'b1);
    run_phase("r4 my", 3'b010, 3'b100, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    run_phase("r4 sg", 3'b100, 3'b001, 1'b0, 2'b00, 1, 1'b0, 1'b1);
    run_phase("r4 sy", 3'b100, 3'b010, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    base_v = 4'd6;

    // Reprogram mid side-green with a walk pending.
    run_phase("r5 mg", 3'b001, 3'b100, 1'b0, 2'b00, 6, 1'b1, 1'b0);
    run_phase("r5 my", 3'b010, 3'b100, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    check_lamps("r5 sg f0", 3'b100, 3'b001, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    check("r5 sg load", 16'(time_left), 16'd6);
    one_hz_enable = TICK;
    @(negedge clk);
    one_hz_enable = ~TICK;
    check("r5 sg count", 16'(time_left), 16'd5);
    sync_reprogram = 1'b1;
    one_hz_enable  = TICK;
    @(negedge clk);
    one_hz_enable = ~TICK;
    check_lamps("sync", 3'b001, 3'b100, 1'b0, 2'b00);
    check("sync time_left", 16'(time_left), 16'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_lamps("sync held", 3'b001, 3'b100, 1'b0, 2'b00);
      check("sync held time_left", 16'(time_left), 16'd0);
    end
    sync_reprogram = 1'b0;
    run_phase("r5 mg2", 3'b001, 3'b100, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r5 my2", 3'b010, 3'b100, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    run_phase("r5 sg2", 3'b100, 3'b001, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r5 sy2", 3'b100, 3'b010, 1'b0, 2'b10, 2, 1'b0, 1'b0);

    // Reset mid yellow with reprogram also high and a walk pending.
    run_phase("r6 mg", 3'b001, 3'b100, 1'b0, 2'b00, 6, 1'b1, 1'b0);
    run_phase("r6 my", 3'b010, 3'b100, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    run_phase("r6 sg", 3'b100, 3'b001, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    check_lamps("r6 sy f0", 3'b100, 3'b010, 1'b0, 2'b10);
    repeat (2) @(negedge clk);
    check("r6 sy load", 16'(time_left), 16'd2);
    one_hz_enable = TICK;
    @(negedge clk);
    one_hz_enable = ~TICK;
    check("r6 sy count", 16'(time_left), 16'd1);
    reset          = 1'b1;
    sync_reprogram = 1'b1;
    @(negedge clk);
    reset          = 1'b0;
    sync_reprogram = 1'b0;
    check_lamps("mid reset", 3'b001, 3'b100, 1'b0, 2'b00);
    check("mid reset time_left", 16'(time_left), 16'd0);
    run_phase("r7 mg", 3'b001, 3'b100, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r7 my", 3'b010, 3'b100, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    run_phase("r7 sg", 3'b100, 3'b001, 1'b0, 2'b00, 6, 1'b0, 1'b0);
    run_phase("r7 sy", 3'b100, 3'b010, 1'b0, 2'b10, 2, 1'b0, 1'b0);
    check_lamps("r7 end", 3'b001, 3'b100, 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_traffic_light_fsm
